// File: rtl/ls161_seq_pkg.sv
// Shared types and helpers for the LS161 counter-chain sequencer.
package ls161_seq_pkg;

  localparam int STAGE_W = 4;
  localparam int MAX_W   = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  // Terminal-count value of a chain with the given number of stages, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] all_ones_value(input int stages);
    logic [MAX_W-1:0] v;
    v = {MAX_W{1'b0}};
    for (int i = 0; i < MAX_W; i++) begin
      if (i < stages * STAGE_W) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/ls161_tc_detect.sv
// W-bit terminal-count comparator: flags when the chain Q bus is all ones.
module ls161_tc_detect
  import ls161_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] cnt_q,
  output logic         is_terminal
);

  localparam logic [W-1:0] TERM_VAL = W'(all_ones_value(W / STAGE_W));

  assign is_terminal = (cnt_q == TERM_VAL);

endmodule

// File: rtl/ls161_sequencer.sv
// Sequencer for a cascade of LS161-style counters (load, run, terminal handling).
// Optional WRAPS saturating TC counter is enabled by defining LS161_SEQ_WRAPCNT_EN.
module ls161_sequencer
  import ls161_seq_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        STOP,
  input  logic                        MODE,
  input  logic [STAGES*STAGE_W-1:0]   PRESET,
  output logic                        READY,
  output logic                        BUSY,
  output logic                        TC,
  input  logic [STAGES*STAGE_W-1:0]   CNT_Q,
  output logic [STAGES*STAGE_W-1:0]   CNT_D,
  output logic                        CNT_CLR_n,
  output logic                        CNT_LOAD_n,
  output logic                        CNT_ENP,
`ifdef LS161_SEQ_WRAPCNT_EN
  output logic [7:0]                  WRAPS,
`endif
  output logic                        CNT_ENT
);

  localparam int W = STAGES * STAGE_W;

  seq_state_e     state_r;
  seq_state_e     next_state_s;
  logic           mode_r;
  logic [W-1:0]   cnt_d_r;
  logic           tc_r;
  logic           clr_n_r;
  logic           tc_set_s;
  logic           load_n_s;
  logic           en_s;
  logic           term_s;
  logic           start_acc_s;

  ls161_tc_detect #(.W(W)) u_tc_detect (
    .cnt_q       (CNT_Q),
    .is_terminal (term_s)
  );

  assign start_acc_s = (state_r == IDLE) && START;

  // Next state and chain control; in RUN the load/enable pins follow CNT_Q combinationally.
  always_comb begin
    next_state_s = state_r;
    load_n_s     = 1'b1;
    en_s         = 1'b0;
    tc_set_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          next_state_s = LOAD;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD: begin
        load_n_s = 1'b0;
        if (STOP) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RUN;
        end
      end
      RUN: begin
        if (STOP) begin
          next_state_s = IDLE;
        end else if (term_s) begin
          tc_set_s = 1'b1;
          if (mode_r) begin
            // Load has priority over count inside the LS161, so enables may stay high.
            load_n_s     = 1'b0;
            en_s         = 1'b1;
            next_state_s = RUN;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          en_s         = 1'b1;
          next_state_s = RUN;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, latched job parameters, TC pulse and the post-reset chain clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      mode_r  <= 1'b0;
      cnt_d_r <= {W{1'b0}};
      tc_r    <= 1'b0;
      clr_n_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      tc_r    <= tc_set_s;
      clr_n_r <= 1'b1;
      if (start_acc_s) begin
        cnt_d_r <= PRESET;
        mode_r  <= MODE;
      end else begin
        cnt_d_r <= cnt_d_r;
        mode_r  <= mode_r;
      end
    end
  end

`ifdef LS161_SEQ_WRAPCNT_EN
  logic [7:0] wraps_r;

  // Saturating count of TC events, restarted by each accepted START.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wraps_r <= 8'd0;
    end else if (start_acc_s) begin
      wraps_r <= 8'd0;
    end else if (tc_set_s && (wraps_r != 8'd255)) begin
      wraps_r <= wraps_r + 8'd1;
    end else begin
      wraps_r <= wraps_r;
    end
  end

  assign WRAPS = wraps_r;
`endif

  assign READY      = (state_r == IDLE);
  assign BUSY       = (state_r == LOAD) || (state_r == RUN);
  assign TC         = tc_r;
  assign CNT_D      = cnt_d_r;
  assign CNT_CLR_n  = clr_n_r;
  assign CNT_LOAD_n = load_n_s;
  assign CNT_ENP    = en_s;
  assign CNT_ENT    = en_s;

endmodule

// File: doc/ls161_sequencer.md
# ls161_sequencer

Controller for a cascade of LS161-style 4-bit synchronous counters, one stage per nibble, chained through ENT/RCO. It latches a preset and mode through a start handshake, drives the chain's parallel-load and enable pins, and watches the chain's Q bus for terminal count. It then either stops (one-shot) or reloads the preset (periodic). It sits between a host control register block and the counter datapath, which it never modifies directly.

## Interface
- STAGES, default 2: number of cascaded 4-bit stages; W = 4*STAGES.
- CLK  in  1  rising-edge clock shared with the counter chain.
- RST  in  1  asynchronous active-high reset.
- START  in  1  start request; accepted only in a cycle where READY=1.
- STOP  in  1  abort request; level-sampled each cycle.
- MODE  in  1  0 = one-shot, 1 = periodic; latched with START.
- PRESET  in  W  count start value; latched with START.
- READY  out  1  sequencer idle and able to accept START.
- BUSY  out  1  a sequence is in progress (LOAD or RUN).
- TC  out  1  one-cycle pulse on each terminal-count event.
- CNT_Q  in  W  chain Q bus, LSB stage in bits [3:0].
- CNT_D  out  W  chain parallel input; holds the latched preset.
- CNT_CLR_n  out  1  chain asynchronous clear, active low.
- CNT_LOAD_n  out  1  chain parallel load, active low.
- CNT_ENP  out  1  chain ENP (all stages).
- CNT_ENT  out  1  ENT of the LSB stage; upper stages take ENT from the previous stage's RCO.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: READY=1, BUSY=0, CNT_LOAD_n=1, CNT_ENP=CNT_ENT=0. START=1 latches PRESET into CNT_D and MODE internally, then moves to LOAD.
- LOAD: CNT_LOAD_n=0 for exactly one cycle, enables 0, then moves to RUN. If STOP=1 in LOAD, the load still happens and the next state is IDLE.
- RUN: CNT_ENP=CNT_ENT=1. Terminal occurs when CNT_Q == all-ones (2^W-1).
  - Terminal with MODE=1: CNT_LOAD_n=0 combinationally in that same cycle, so the load overrides the count. TC pulses the next cycle. State stays RUN.
  - Terminal with MODE=0: enables drop combinationally in that cycle, so Q holds at all-ones. TC pulses the next cycle. Next state is IDLE.
- Period in periodic mode is 2^W - PRESET cycles. PRESET = all-ones gives a period of 1, with TC high continuously.
- STOP=1 in RUN: enables are 0 combinationally and the next state is IDLE. The counter holds its value and is not cleared. STOP beats a simultaneous terminal: no reload and no TC.
- START while BUSY is ignored. START and STOP together in IDLE: START is accepted.
- CNT_D changes only on an accepted START.

## Timing
- Reset values: state IDLE, READY=1, BUSY=0, TC=0, CNT_D=0, CNT_LOAD_n=1, CNT_ENP=CNT_ENT=0, CNT_CLR_n=0.
- CNT_CLR_n is registered. It stays 0 for the whole of RST and the first clock edge after RST deasserts, then goes 1.
- START accepted at edge k: LOAD at k+1, counter holds PRESET after k+2, first increment at k+3.
- TC is registered: one cycle after the terminal cycle.
- CNT_LOAD_n and enables in RUN are combinational from state, STOP and CNT_Q. This is the only combinational path from CNT_Q.
- READY and BUSY are decoded from the registered state.

## Configuration
- LS161_SEQ_WRAPCNT_EN defined: adds an output WRAPS (out, 8 bits).
  - Counts TC events and saturates at 255.
  - Cleared to 0 on an accepted START and on RST.
- Not defined: no WRAPS port and no counter logic. All other behaviour is identical.

## Structure
- Package ls161_seq_pkg holds:
  - the state enum (IDLE, LOAD, RUN);
  - STAGE_W=4;
  - a function returning the all-ones terminal value for a given STAGES.
- One sub-module, ls161_tc_detect: a parameterised W-bit all-ones comparator, also used by verification as a reference model.

## Test plan
- Reset: assert RST mid-RUN → all outputs take their reset values immediately, CNT_CLR_n=0, and CNT_CLR_n=1 one edge after RST release.
- One-shot, STAGES=2, PRESET=0xF0, MODE=0 → counter counts 0xF0..0xFF, one TC pulse, READY=1, Q held at 0xFF.
- Periodic, PRESET=0xFC, MODE=1 → TC every 4 cycles, Q sequence FC, FD, FE, FF, FC…, no 0x00 ever seen.
- STOP in the same cycle Q=0xFF in periodic mode → no TC, no reload, IDLE next, Q=0xFF held.
- START pulsed during RUN with a different PRESET → ignored, CNT_D unchanged, period unchanged.
- LS161_SEQ_WRAPCNT_EN defined, periodic PRESET=0xFF for 300 cycles → WRAPS saturates at 255; a new START clears it to 0.
